// File: rtl/pipe_stage_skid_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// One pipeline stage that sits between two valid/ready handshakes. It has a
// 2-entry skid buffer, so upstream can stream at full rate while in_ready is
// driven from registered state only, never from out_ready.
//
// Each entry carries a PC, a branch-delay flag, an exception code and an
// opaque payload. Three control inputs change the normal flow:
//   req   : exception redirect. Kills both entries and parks out_pc on
//           HANDLER_PC.
//   flush : inserts an invalid bubble. The bubble carries in_pc/in_bd, so
//           CP0 still sees the right PC. Each bubble inserted this way
//           increments a saturating counter.
//   reset : asynchronous, active-low.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req        in   exception/interrupt redirect (highest priority)
//   flush      in   stall-bubble insertion request
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept an entry this cycle
//   in_pc      in   upstream PC
//   in_bd      in   upstream branch-delay flag
//   in_exc     in   upstream exception code
//   in_data    in   upstream payload
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts the head entry
//   out_pc     out  head PC; still meaningful when out_valid=0
//   out_bd     out  head branch-delay flag
//   out_exc    out  head exception code (0 when empty)
//   out_data   out  head payload (0 when empty)
//   bubble_cnt out  saturating count of bubbles inserted by flush
// -----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int          DATA_W     = 129,
  parameter int          EXC_W      = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main slot invalid
    ST_ONE   = 2'd1,  // main valid, skid empty
    ST_TWO   = 2'd2   // main and skid valid
  } state_t;

  // What the main slot loads on the next edge.
  typedef enum logic [2:0] {
    LD_NONE    = 3'd0,
    LD_IN      = 3'd1,
    LD_SKID    = 3'd2,
    LD_BUBBLE  = 3'd3,
    LD_HANDLER = 3'd4
  } ld_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t state_q;
  state_t state_d;
  ld_t    main_ld;
  logic   skid_ld;
  logic   accept;
  logic   drain;

  logic [31:0]       main_pc_p1;
  logic              main_bd_p1;
  logic [EXC_W-1:0]  main_exc_p1;
  logic [DATA_W-1:0] main_data_p1;

  logic [31:0]       skid_pc_p1;
  logic              skid_bd_p1;
  logic [EXC_W-1:0]  skid_exc_p1;
  logic [DATA_W-1:0] skid_data_p1;

  // in_ready is registered in the skid state and combinational only in
  // flush/req. This keeps out_ready off the in_ready path.
  assign in_ready  = (state_q != ST_TWO) & ~flush & ~req;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. While flush is high, accept is always 0, so only the
  // drain term moves the state. A bubble is an invalid entry, so inserting
  // one leaves the stage EMPTY.
  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (drain && !accept)      state_d = ST_EMPTY;
          else if (accept && !drain) state_d = ST_TWO;
        end
        ST_TWO:   if (drain) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot load controls. A flush takes effect only when the main slot is free
  // or is leaving this cycle, and the skid slot is empty. Otherwise the flush
  // is ignored and upstream asserts it again.
  always_comb begin
    main_ld = LD_NONE;
    skid_ld = 1'b0;
    if (req) begin
      main_ld = LD_HANDLER;
    end else if (flush) begin
      if (state_q == ST_EMPTY || (state_q == ST_ONE && drain)) begin
        main_ld = LD_BUBBLE;
      end else if (state_q == ST_TWO && drain) begin
        main_ld = LD_SKID;
      end
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) main_ld = LD_IN;
        ST_ONE: begin
          if (accept && drain)  main_ld = LD_IN;
          else if (accept)      skid_ld = 1'b1;
        end
        ST_TWO:   if (drain) main_ld = LD_SKID;
        default:  main_ld = LD_NONE;
      endcase
    end
  end

  // ---- stage boundary: main slot (architecturally visible PC/BD) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_pc_p1 <= RESET_PC;
      main_bd_p1 <= 1'b0;
    end else begin
      case (main_ld)
        LD_IN:      begin main_pc_p1 <= in_pc;      main_bd_p1 <= in_bd;      end
        LD_SKID:    begin main_pc_p1 <= skid_pc_p1; main_bd_p1 <= skid_bd_p1; end
        LD_BUBBLE:  begin main_pc_p1 <= in_pc;      main_bd_p1 <= in_bd;      end
        LD_HANDLER: begin main_pc_p1 <= HANDLER_PC; main_bd_p1 <= 1'b0;       end
        default:    ;
      endcase
    end
  end

  // Payload is masked by out_valid at the output, so it needs no reset.
  always_ff @(posedge clk) begin
    case (main_ld)
      LD_IN:      begin main_exc_p1 <= in_exc;      main_data_p1 <= in_data;      end
      LD_SKID:    begin main_exc_p1 <= skid_exc_p1; main_data_p1 <= skid_data_p1; end
      LD_BUBBLE,
      LD_HANDLER: begin main_exc_p1 <= '0;          main_data_p1 <= '0;           end
      default:    ;
    endcase
  end

  // ---- stage boundary: skid slot (its validity is carried by state_q) ----
  always_ff @(posedge clk) begin
    if (skid_ld) begin
      skid_pc_p1   <= in_pc;
      skid_bd_p1   <= in_bd;
      skid_exc_p1  <= in_exc;
      skid_data_p1 <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (main_ld == LD_BUBBLE) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  assign out_pc   = main_pc_p1;
  assign out_bd   = main_bd_p1;
  assign out_exc  = out_valid ? main_exc_p1  : '0;
  assign out_data = out_valid ? main_data_p1 : '0;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
`timescale 1ns/1ps
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 129;
  localparam int EXC_W  = 5;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] HND_PC = 32'h0000_4180;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pc = '0;
  logic              in_bd = 1'b0;
  logic [EXC_W-1:0]  in_exc = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic              out_bd;
  logic [EXC_W-1:0]  out_exc;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .EXC_W(EXC_W), .RESET_PC(RST_PC),
    .HANDLER_PC(HND_PC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_bd(out_bd),
    .out_exc(out_exc), .out_data(out_data), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two entries, the last visible PC/BD,
  // and a saturating bubble count.
  typedef struct {
    logic [31:0]       pc;
    logic              bd;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc  = RST_PC;
  logic        m_bd  = 1'b0;
  int          m_cnt = 0;
  int          m_n;
  bit          m_dr;
  bit          m_ac;
  ent_t        m_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pc  = RST_PC;
      m_bd  = 1'b0;
      m_cnt = 0;
    end else begin
      m_n = mq.size();
      if (req) begin
        mq.delete();
        m_pc = HND_PC;
        m_bd = 1'b0;
      end else begin
        m_dr = (m_n > 0) && out_ready;
        m_ac = in_valid && (m_n < 2) && !flush;
        m_e.pc = in_pc; m_e.bd = in_bd; m_e.exc = in_exc; m_e.data = in_data;
        if (m_dr) void'(mq.pop_front());
        if (m_ac) mq.push_back(m_e);
        if (flush && (m_n < 2) && (m_n == 0 || m_dr)) begin
          m_pc = in_pc;
          m_bd = in_bd;
          if (m_cnt < CMAX) m_cnt++;
        end
        if (mq.size() > 0) begin
          m_pc = mq[0].pc;
          m_bd = mq[0].bd;
        end
      end
    end
  end

  // Compare process: every cycle, mid-period.
  logic [DATA_W-1:0] e_data;
  logic [EXC_W-1:0]  e_exc;
  always @(negedge clk) begin
    if (chk_en) begin
      e_data = (mq.size() > 0) ? mq[0].data : '0;
      e_exc  = (mq.size() > 0) ? mq[0].exc  : '0;
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'((mq.size() < 2) && !flush && !req));
      chk("out_pc", out_pc, m_pc);
      chk("out_bd", 32'(out_bd), 32'(m_bd));
      chk("out_exc", 32'(out_exc), 32'(e_exc));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
      checks++;
      if (out_data !== e_data) begin
        errors++;
        $display("FAIL out_data: got %h expected %h at %0t", out_data, e_data, $time);
      end
    end
  end

  // Drive one cycle of inputs, then return 2ns after the edge that used them.
  task automatic drv(input bit v, input logic [31:0] pc, input bit bd,
                     input bit orr, input bit fl, input bit rq);
    in_valid  = v;
    in_pc     = pc;
    in_bd     = bd;
    in_exc    = pc[6:2];
    in_data   = {pc, ~pc, pc, ~pc, bd};
    out_ready = orr;
    flush     = fl;
    req       = rq;
    @(posedge clk);
    #2;
  endtask

  int exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst out_pc", out_pc, 32'h0000_3000);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst bubble_cnt", 32'(bubble_cnt), 32'd0);

    // Streaming with out_ready high: 1-cycle latency, no bubbles.
    drv(1, 32'h3000, 0, 1, 0, 0);
    chk("stream pc0", out_pc, 32'h3000);
    chk("stream v0", 32'(out_valid), 32'd1);
    drv(1, 32'h3004, 0, 1, 0, 0);
    chk("stream pc1", out_pc, 32'h3004);
    chk("stream rdy1", 32'(in_ready), 32'd1);
    drv(1, 32'h3008, 0, 1, 0, 0);
    chk("stream pc2", out_pc, 32'h3008);
    drv(0, 32'h3008, 0, 1, 0, 0);
    chk("stream empty hold pc", out_pc, 32'h3008);

    // Backpressure fills the skid slot.
    drv(1, 32'h3000, 0, 0, 0, 0);
    drv(1, 32'h3004, 0, 0, 0, 0);
    chk("bp in_ready TWO", 32'(in_ready), 32'd0);
    chk("bp head", out_pc, 32'h3000);
    drv(1, 32'h3008, 0, 1, 0, 0);
    chk("bp second", out_pc, 32'h3004);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    drv(1, 32'h3008, 0, 1, 0, 0);
    chk("bp third", out_pc, 32'h3008);
    drv(0, 32'h3008, 0, 1, 0, 0);

    // Flush into an empty stage, then re-present the input.
    drv(1, 32'h3010, 1, 1, 1, 0);
    chk("flush valid", 32'(out_valid), 32'd0);
    chk("flush pc", out_pc, 32'h3010);
    chk("flush bd", 32'(out_bd), 32'd1);
    chk("flush cnt", 32'(bubble_cnt), 32'd1);
    drv(1, 32'h3010, 1, 1, 0, 0);
    chk("flush reaccept", 32'(out_valid), 32'd1);
    drv(0, 32'h3010, 0, 1, 0, 0);

    // req with flush while holding two entries.
    drv(1, 32'h3020, 0, 0, 0, 0);
    drv(1, 32'h3024, 0, 0, 0, 0);
    drv(1, 32'h3028, 1, 0, 1, 1);
    chk("req valid", 32'(out_valid), 32'd0);
    chk("req pc", out_pc, 32'h4180);
    chk("req bd", 32'(out_bd), 32'd0);
    chk("req cnt", 32'(bubble_cnt), 32'd1);
    drv(1, 32'h3030, 0, 1, 0, 0);
    chk("post req head", out_pc, 32'h3030);
    drv(1, 32'h3040, 1, 0, 1, 0);
    chk("flush blocked pc", out_pc, 32'h3030);
    chk("flush blocked cnt", 32'(bubble_cnt), 32'd1);
    drv(1, 32'h3044, 0, 1, 1, 0);
    chk("flush drain pc", out_pc, 32'h3044);
    chk("flush drain valid", 32'(out_valid), 32'd0);
    chk("flush drain cnt", 32'(bubble_cnt), 32'd2);

    // Asynchronous reset mid-stream with two entries held.
    drv(1, 32'h3050, 0, 0, 0, 0);
    drv(1, 32'h3054, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("arst valid", 32'(out_valid), 32'd0);
    chk("arst pc", out_pc, 32'h3000);
    chk("arst cnt", 32'(bubble_cnt), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;

    // Saturating bubble counter.
    for (int i = 0; i < 5; i++) begin
      drv(0, 32'h3060 + 32'(4 * i), 0, 1, 1, 0);
      chk("sat cnt", 32'(bubble_cnt), 32'(exp_cnt[i]));
    end
    chk("sat last pc", out_pc, 32'h3070);
    drv(0, 32'h3070, 0, 1, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
